conv_result_axis_packer: RTL and testbench

- Output stage directly downstream of the final 3x3 convolution core.
- Consumes per-pixel signed accumulator pairs (channel A, channel B).
- Applies ReLU, scaling by right shift, and saturation to 8 bits, then packs 4 pixels (8 bytes) per AXI-Stream beat.
- Buffers beats in a FIFO to absorb downstream backpressure, since the conv pipeline cannot stall. Asserts tlast and a done pulse at frame end.

---
 rtl/conv_result_axis_packer.sv | 193 +++++++++++++++++++
 tb/tb_conv_result_axis_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_axis_packer.sv
// rtl/conv_result_axis_packer.sv - ReLU/shift/saturate conv sums, pack 4 pixels per AXIS beat, buffer in FIFO.
// Optional CONV_PACKER_ROUND_EN: round half up before the shift instead of truncating.
module conv_result_axis_packer #(
  parameter int SUM_WIDTH       = 35,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int QUANT_SHIFT     = 10,
  parameter int FIFO_DEPTH      = 16,
  parameter int PIX_CNT_WIDTH   = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [PIX_CNT_WIDTH-1:0]     i_total_pixels,
  input  logic                         i_valid,
  input  logic [SUM_WIDTH-1:0]         i_sum_a,
  input  logic [SUM_WIDTH-1:0]         i_sum_b,
  output logic                         o_almost_full,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overflow
);
  localparam int KEEP_W  = AXIS_DATA_WIDTH / 8;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = AXIS_DATA_WIDTH + KEEP_W + 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(FIFO_DEPTH - 2);
`ifdef CONV_PACKER_ROUND_EN
  localparam logic [SUM_WIDTH:0] RND = (SUM_WIDTH+1)'(1) << (QUANT_SHIFT - 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  // One extra bit on the sum so the rounding add cannot wrap near full scale.
  function automatic logic [7:0] quant(input logic [SUM_WIDTH-1:0] s);
    logic [SUM_WIDTH:0] ext;
    logic [SUM_WIDTH:0] sh;
    ext = {1'b0, s};
`ifdef CONV_PACKER_ROUND_EN
    ext = ext + RND;
`endif
    sh = ext >> QUANT_SHIFT;
    if (s[SUM_WIDTH-1])
      quant = 8'd0;
    else if (|sh[SUM_WIDTH:8])
      quant = 8'hFF;
    else
      quant = sh[7:0];
  endfunction

  logic [PIX_CNT_WIDTH-1:0] total_q, pix_cnt, pix_nxt;
  logic                     start_ok, accept, drop_in, is_last;
  logic                     q_valid, q_last;
  logic [7:0]               q_a, q_b;
  logic [AXIS_DATA_WIDTH-1:0] pack_data, beat_data;
  logic [KEEP_W-1:0]        beat_keep;
  logic [1:0]               k;
  logic                     push, pop, full, wr_en, ovf_push, last_hs;
  logic [ENTRY_W-1:0]       mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]       head;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;

  assign start_ok = (state == IDLE) && i_start && (i_total_pixels != '0);
  assign accept   = (state == RUN) && i_valid;
  assign drop_in  = i_valid && (state != RUN);
  assign pix_nxt  = pix_cnt + PIX_CNT_WIDTH'(1);
  assign is_last  = (pix_nxt == total_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (accept && is_last) state_nxt = FLUSH;
      FLUSH:   if (last_hs) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
    o_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      pix_cnt <= '0;
    end else if (start_ok) begin
      total_q <= i_total_pixels;
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= pix_nxt;
    end
  end

  // Stage 1: quantize both channels and carry the frame-end tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q_a     <= '0;
      q_b     <= '0;
    end else begin
      q_valid <= accept;
      q_last  <= accept && is_last;
      if (accept) begin
        q_a <= quant(i_sum_a);
        q_b <= quant(i_sum_b);
      end
    end
  end

  always_comb begin
    beat_data = pack_data;
    beat_keep = '0;
    case (k)
      2'd0: begin beat_data[15:0]  = {q_b, q_a}; beat_keep = 8'h03; end
      2'd1: begin beat_data[31:16] = {q_b, q_a}; beat_keep = 8'h0F; end
      2'd2: begin beat_data[47:32] = {q_b, q_a}; beat_keep = 8'h3F; end
      default: begin beat_data[63:48] = {q_b, q_a}; beat_keep = 8'hFF; end
    endcase
  end

  assign push = q_valid && ((k == 2'd3) || q_last);

  // Stage 2: the pack register is cleared on every push so partial beats carry zero bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      k         <= '0;
    end else if (start_ok) begin
      pack_data <= '0;
      k         <= '0;
    end else if (q_valid) begin
      if (push) begin
        pack_data <= '0;
        k         <= '0;
      end else begin
        pack_data <= beat_data;
        k         <= k + 2'd1;
      end
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[ENTRY_W-1 -: AXIS_DATA_WIDTH] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[KEEP_W:1] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[0];
  assign o_almost_full = (count >= AF_C);
  assign full          = (count == DEPTH_C);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign wr_en         = push && (!full || pop);
  assign ovf_push      = push && full && !pop;
  assign last_hs       = pop && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {beat_data, beat_keep, q_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    o_overflow <= 1'b0;
    else if (drop_in || ovf_push)  o_overflow <= 1'b1;
    else if (start_ok)             o_overflow <= 1'b0;
  end
endmodule

// File: tb/tb_conv_result_axis_packer.sv
// tb/tb_conv_result_axis_packer.sv - directed table-driven bench for conv_result_axis_packer.
module tb_conv_result_axis_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [19:0] i_total_pixels;
  logic        i_valid;
  logic [34:0] i_sum_a, i_sum_b;
  logic        o_almost_full, m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        o_busy, o_done, o_overflow;

  conv_result_axis_packer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_total_pixels(i_total_pixels),
    .i_valid(i_valid), .i_sum_a(i_sum_a), .i_sum_b(i_sum_b),
    .o_almost_full(o_almost_full), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] a;
    logic [34:0] b;
    logic [7:0]  ea;
    logic [7:0]  eb;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_last_cyc = -1;
  beat_t bq[$];
  logic [34:0] pa [0:127];
  logic [34:0] pb [0:127];
  vec_t vecs [6];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        bq.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
        if (m_axis_tlast) hs_last_cyc = cyc_n;
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc_n;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_pix(input int idx);
    i_valid = 1'b1;
    i_sum_a = pa[idx];
    i_sum_b = pb[idx];
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic start_frame(input int total);
    i_start = 1'b1;
    i_total_pixels = 20'(total);
    cyc();
    i_start = 1'b0;
  endtask

  task automatic run_frame(input int total);
    int snap;
    int t;
    snap = done_cnt;
    start_frame(total);
    for (int i = 0; i < total; i++) send_pix(i);
    t = 0;
    while (done_cnt == snap && t < 300) begin
      cyc();
      t++;
    end
    chk("frame_done_seen", 64'(done_cnt != snap), 64'd1);
    repeat (3) cyc();
    chk("done_pulse_width", 64'(done_cnt - snap), 64'd1);
  endtask

  function automatic logic [63:0] stall_beat(input int j);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[16*i +: 8]     = 8'(4*j + i + 1);
      w[16*i + 8 +: 8] = 8'(4*j + i + 101);
    end
    return w;
  endfunction

  initial begin
    int snap;
    logic [63:0] held;
    vecs[0] = '{a: 35'(300 << 10), b: 35'd1023, ea: 8'hFF, eb: 8'h00};
    vecs[1] = '{a: 35'h7_FFFF_FFFF, b: 35'((255 << 10) + 1023), ea: 8'h00, eb: 8'hFF};
`ifdef CONV_PACKER_ROUND_EN
    vecs[2] = '{a: 35'd1536, b: 35'(255 << 10), ea: 8'h02, eb: 8'hFF};
`else
    vecs[2] = '{a: 35'd1536, b: 35'(255 << 10), ea: 8'h01, eb: 8'hFF};
`endif
    vecs[3] = '{a: 35'd1535, b: 35'(256 << 10), ea: 8'h01, eb: 8'hFF};
    vecs[4] = '{a: 35'h3_FFFF_FFFF, b: 35'h4_0000_0000, ea: 8'hFF, eb: 8'h00};
    vecs[5] = '{a: 35'd0, b: 35'(5 << 10), ea: 8'h00, eb: 8'h05};

    rst_n = 1'b0; i_start = 1'b0; i_total_pixels = '0; i_valid = 1'b0;
    i_sum_a = '0; i_sum_b = '0; m_axis_tready = 1'b1;
    repeat (3) cyc();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
    chk("rst_busy_done", 64'({o_busy, o_done}), 64'd0);
    chk("rst_ovf_af", 64'({o_overflow, o_almost_full}), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Idle drops and ignored zero-length start
    i_valid = 1'b1; cyc(); i_valid = 1'b0; cyc();
    chk("idle_valid_ovf", 64'(o_overflow), 64'd1);
    start_frame(0); cyc();
    chk("zero_total_ignored", 64'(o_busy), 64'd0);

    // Two full beats, B negative
    for (int n = 0; n < 8; n++) begin
      pa[n] = 35'((n + 1) * 1024);
      pb[n] = -35'sd3;
    end
    bq.delete();
    run_frame(8);
    chk("t1_nbeats", 64'(bq.size()), 64'd2);
    chk("t1_b0_data", bq[0].d, 64'h0004_0003_0002_0001);
    chk("t1_b0_keep_last", 64'({bq[0].k, bq[0].l}), 64'h1FE);
    chk("t1_b1_data", bq[1].d, 64'h0008_0007_0006_0005);
    chk("t1_b1_keep_last", 64'({bq[1].k, bq[1].l}), 64'h1FF);
    chk("t1_done_after_hs", 64'(done_cyc - hs_last_cyc), 64'd1);
    chk("t1_ovf", 64'(o_overflow), 64'd0);
    chk("t1_idle", 64'(o_busy), 64'd0);

    // Quantization table, one pixel per frame
    for (int v = 0; v < 6; v++) begin
      pa[0] = vecs[v].a;
      pb[0] = vecs[v].b;
      bq.delete();
      run_frame(1);
      chk($sformatf("q%0d_nbeats", v), 64'(bq.size()), 64'd1);
      chk($sformatf("q%0d_data", v), bq[0].d, {48'd0, vecs[v].eb, vecs[v].ea});
      chk($sformatf("q%0d_keep_last", v), 64'({bq[0].k, bq[0].l}), 64'h007);
    end

    // Partial final beat
    for (int n = 0; n < 6; n++) begin
      pa[n] = 35'((n + 1) << 10);
      pb[n] = 35'((n + 11) << 10);
    end
    bq.delete();
    run_frame(6);
    chk("t3_nbeats", 64'(bq.size()), 64'd2);
    chk("t3_b0_data", bq[0].d, 64'h0E04_0D03_0C02_0B01);
    chk("t3_b0_keep_last", 64'({bq[0].k, bq[0].l}), 64'h1FE);
    chk("t3_b1_data", bq[1].d, 64'h0000_0000_1006_0F05);
    chk("t3_b1_keep_last", 64'({bq[1].k, bq[1].l}), 64'h01F);

    // Backpressure: 20 beats into a 16-deep FIFO
    for (int p = 0; p < 80; p++) begin
      pa[p] = 35'((p + 1) << 10);
      pb[p] = 35'((p + 101) << 10);
    end
    m_axis_tready = 1'b0;
    start_frame(80);
    for (int b = 1; b <= 20; b++) begin
      for (int i = 0; i < 4; i++) send_pix(4*(b-1) + i);
      repeat (2) cyc();
      chk($sformatf("t4_af_b%0d", b), 64'(o_almost_full), 64'(b >= 14));
      chk($sformatf("t4_ovf_b%0d", b), 64'(o_overflow), 64'(b >= 17));
    end
    held = m_axis_tdata;
    chk("t4_head_stalled", held, stall_beat(0));
    repeat (3) cyc();
    chk("t4_head_stable", m_axis_tdata, stall_beat(0));
    bq.delete();
    m_axis_tready = 1'b1;
    repeat (40) cyc();
    chk("t4_drained", 64'(bq.size()), 64'd16);
    for (int j = 0; j < 16; j++)
      chk($sformatf("t4_beat%0d", j), {bq[j].d[62:0], bq[j].l}, {stall_beat(j)[62:0], 1'b0});
    chk("t4_af_after", 64'(o_almost_full), 64'd0);
    chk("t4_still_busy", 64'(o_busy), 64'd1);

    // Reset mid-frame, then a fresh short frame
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    m_axis_tready = 1'b0;
    start_frame(40);
    for (int i = 0; i < 20; i++) send_pix(i);
    repeat (3) cyc();
    chk("t5_queued", 64'(m_axis_tvalid), 64'd1);
    snap = done_cnt;
    bq.delete();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_rst_busy", 64'(o_busy), 64'd0);
    m_axis_tready = 1'b1;
    cyc();
    chk("t5_rst_edge", 64'({m_axis_tvalid, m_axis_tlast, o_busy}), 64'd0);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("t5_no_emit", 64'({bq.size(), done_cnt - snap}), 64'd0);
    for (int n = 0; n < 4; n++) begin
      pa[n] = 35'((n + 1) << 10);
      pb[n] = 35'((n + 21) << 10);
    end
    run_frame(4);
    chk("t5_nbeats", 64'(bq.size()), 64'd1);
    chk("t5_data", bq[0].d, 64'h1804_1703_1602_1501);
    chk("t5_keep_last", 64'({bq[0].k, bq[0].l}), 64'h1FF);
    chk("t5_ovf", 64'(o_overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
